// File: rtl/store_buffer.sv
// Store buffer: encodes RISC-V SB/SH/SW stores into byte-lane writes, queues them
// in a DEPTH-entry FIFO and drains the head to data memory under a req/ack handshake.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [2:0]  st_funct3,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_stall,
  output logic        st_fault,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        sb_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [29:0]   addr_q  [DEPTH];
  logic [29:0]   addr_d  [DEPTH];
  logic [31:0]   wdata_q [DEPTH];
  logic [31:0]   wdata_d [DEPTH];
  logic [3:0]    be_q    [DEPTH];
  logic [3:0]    be_d    [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fault_q, fault_d;

  logic [3:0]    enc_be;
  logic [31:0]   enc_wdata;
  logic          enc_legal;
  logic          enc_misalign;
  logic          full, empty, accept, push, pop;
  logic [AW-1:0] offset;

  always_comb begin
    enc_be       = 4'b0000;
    enc_wdata    = 32'h0;
    enc_legal    = 1'b1;
    enc_misalign = 1'b0;
    case (st_funct3)
      3'b000: begin
        enc_be    = 4'b0001 << st_addr[1:0];
        enc_wdata = {4{st_data[7:0]}};
      end
      3'b001: begin
        enc_be       = st_addr[1] ? 4'b1100 : 4'b0011;
        enc_wdata    = {2{st_data[15:0]}};
        enc_misalign = st_addr[0];
      end
      3'b010: begin
        enc_be       = 4'b1111;
        enc_wdata    = st_data;
        enc_misalign = |st_addr[1:0];
      end
      default: enc_legal = 1'b0;
    endcase
  end

  always_comb begin
    full   = (count_q == CW'(DEPTH));
    empty  = (count_q == '0);
    // A stalled store is invisible: it neither enqueues nor faults.
    accept = st_valid && !full;
    push   = accept && enc_legal && !enc_misalign;
    pop    = !empty && mem_ack;

    fault_d  = accept && !(enc_legal && !enc_misalign);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    for (int i = 0; i < int'(DEPTH); i++) begin
      addr_d[i]  = addr_q[i];
      wdata_d[i] = wdata_q[i];
      be_d[i]    = be_q[i];
    end
    if (push) begin
      addr_d[wr_ptr_q]  = st_addr[31:2];
      wdata_d[wr_ptr_q] = enc_wdata;
      be_d[wr_ptr_q]    = enc_be;
    end
  end

  // Entry is live when its distance from the head is below the count.
  always_comb begin
    ld_hazard = 1'b0;
    offset    = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      offset = AW'(i) - rd_ptr_q;
      if (({1'b0, offset} < count_q) && (addr_q[i] == ld_addr[31:2])) begin
        ld_hazard = 1'b1;
      end
    end
  end

  always_comb begin
    st_stall  = full;
    st_fault  = fault_q;
    sb_empty  = empty;
    mem_req   = !empty;
    mem_addr  = {addr_q[rd_ptr_q], 2'b00};
    mem_wdata = wdata_q[rd_ptr_q];
    mem_be    = be_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      fault_q  <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      addr_q[i]  <= addr_d[i];
      wdata_q[i] <= wdata_d[i];
      be_q[i]    <= be_d[i];
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a scoreboard queue holds the expected memory
// writes in order and is checked whenever the DUT completes a req/ack handshake.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_stall;
  logic        st_fault;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        sb_empty;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  ent_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_funct3 (st_funct3),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_stall  (st_stall),
    .st_fault  (st_fault),
    .ld_addr   (ld_addr),
    .ld_hazard (ld_hazard),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .sb_empty  (sb_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Settle, score any handshake completing at the coming edge, then advance one cycle.
  task automatic tick();
    ent_t e;
    #1;
    if (mem_req === 1'b1 && mem_ack === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("extra_req", {31'b0, mem_req}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_wdata", mem_wdata, e.wdata);
        chk("mem_be", {28'b0, mem_be}, {28'b0, e.be});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid  = 1'b1;
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_funct3 = 3'b000; st_addr = '0; st_data = '0;
    ld_addr = 32'hFFFF_FFF0; mem_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_sb_empty", {31'b0, sb_empty}, 32'd1);
    chk("rst_st_stall", {31'b0, st_stall}, 32'd0);
    chk("rst_ld_hazard", {31'b0, ld_hazard}, 32'd0);
    chk("rst_st_fault", {31'b0, st_fault}, 32'd0);

    // SB to the top byte lane, ack held high.
    store(3'b000, 32'h1003, 32'hAABBCCDD);
    mem_ack = 1'b1;
    sbq.push_back('{32'h1000, 32'hDDDDDDDD, 4'b1000});
    tick();
    st_valid = 1'b0;
    #1 chk("sb_req", {31'b0, mem_req}, 32'd1);
    tick();
    chk("sb_drained", {31'b0, sb_empty}, 32'd1);

    // SH aligned, then misaligned.
    mem_ack = 1'b0;
    store(3'b001, 32'h2002, 32'h00001234);
    sbq.push_back('{32'h2000, 32'h12341234, 4'b1100});
    tick();
    st_valid = 1'b0;
    #1 chk("sh_no_fault", {31'b0, st_fault}, 32'd0);
    chk("sh_req", {31'b0, mem_req}, 32'd1);
    store(3'b001, 32'h2001, 32'h00005678);
    tick();
    st_valid = 1'b0;
    chk("sh_mis_fault", {31'b0, st_fault}, 32'd1);
    tick();
    chk("fault_one_cycle", {31'b0, st_fault}, 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1 chk("sh_mis_not_queued", {31'b0, sb_empty}, 32'd1);

    // Illegal funct3 and misaligned SW both fault without queuing.
    store(3'b011, 32'h0000_0010, 32'h0);
    tick();
    st_valid = 1'b0;
    chk("illegal_fault", {31'b0, st_fault}, 32'd1);
    store(3'b010, 32'h4002, 32'h12345678);
    tick();
    st_valid = 1'b0;
    chk("sw_mis_fault", {31'b0, st_fault}, 32'd1);
    tick();
    chk("faults_not_queued", {31'b0, sb_empty}, 32'd1);

    store(3'b000, 32'h1001, 32'h0000005A);
    mem_ack = 1'b1;
    sbq.push_back('{32'h1000, 32'h5A5A5A5A, 4'b0010});
    tick();
    st_valid = 1'b0;
    tick();
    chk("sb_lane1_drained", {31'b0, sb_empty}, 32'd1);

    // Fill the buffer with ack held low.
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(3'b010, 32'h3000 + 32'(i * 16), 32'h11111111 * 32'(i + 1));
      sbq.push_back('{32'h3000 + 32'(i * 16), 32'h11111111 * 32'(i + 1), 4'b1111});
      #1 chk("fill_no_stall", {31'b0, st_stall}, 32'd0);
      tick();
    end
    st_valid = 1'b0;
    #1 chk("full_stall", {31'b0, st_stall}, 32'd1);
    ld_addr = 32'h3002;
    #1 chk("hazard_hit", {31'b0, ld_hazard}, 32'd1);
    ld_addr = 32'h3004;
    #1 chk("hazard_miss", {31'b0, ld_hazard}, 32'd0);
    ld_addr = 32'h3030;
    #1 chk("hazard_tail", {31'b0, ld_hazard}, 32'd1);
    store(3'b010, 32'h5000, 32'hDEADBEEF);
    tick();
    st_valid = 1'b0;
    chk("stalled_no_fault", {31'b0, st_fault}, 32'd0);
    chk("still_full", {31'b0, st_stall}, 32'd1);

    // Full with both store and ack: one pop, store dropped.
    store(3'b010, 32'h6000, 32'h66666666);
    mem_ack = 1'b1;
    tick();
    st_valid = 1'b0;
    mem_ack = 1'b0;
    #1 chk("stall_drops", {31'b0, st_stall}, 32'd0);
    ld_addr = 32'h3000;
    #1 chk("popped_no_hazard", {31'b0, ld_hazard}, 32'd0);
    mem_ack = 1'b1;
    repeat (3) tick();
    mem_ack = 1'b0;
    #1 chk("full_drained", {31'b0, sb_empty}, 32'd1);

    // Back-to-back stores with ack high: push and pop together.
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      store(3'b000, 32'h8000 + 32'(i), 32'h10 + 32'(i));
      sbq.push_back('{32'h8000, {4{8'(8'h10 + i)}}, 4'(4'b0001 << i)});
      tick();
    end
    st_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (sb_empty === 1'b1) break;
      tick();
    end
    chk("stream_empty", {31'b0, sb_empty}, 32'd1);
    chk("stream_leftover", 32'(sbq.size()), 32'd0);

    // Hazard excludes the store being enqueued, includes the head being acked.
    mem_ack = 1'b0;
    ld_addr = 32'h7000;
    store(3'b010, 32'h7000, 32'hCAFEF00D);
    sbq.push_back('{32'h7000, 32'hCAFEF00D, 4'b1111});
    #1 chk("hazard_excl_enq", {31'b0, ld_hazard}, 32'd0);
    tick();
    st_valid = 1'b0;
    #1 chk("hazard_pending", {31'b0, ld_hazard}, 32'd1);
    mem_ack = 1'b1;
    #1 chk("hazard_acked_head", {31'b0, ld_hazard}, 32'd1);
    tick();
    mem_ack = 1'b0;
    #1 chk("hazard_cleared", {31'b0, ld_hazard}, 32'd0);

    // Reset with two pending entries discards them.
    store(3'b010, 32'h9000, 32'h1);
    tick();
    store(3'b010, 32'h9004, 32'h2);
    tick();
    st_valid = 1'b0;
    #1 chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sbq.delete();
    chk("post_rst_req", {31'b0, mem_req}, 32'd0);
    chk("post_rst_empty", {31'b0, sb_empty}, 32'd1);
    mem_ack = 1'b1;
    tick();
    tick();
    chk("late_ack_req", {31'b0, mem_req}, 32'd0);
    chk("late_ack_empty", {31'b0, sb_empty}, 32'd1);
    mem_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4 (power of two, 2..16), giving the number of pending store entries.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port st_valid, input, 1, store request from the MEM stage this cycle.
REQ-005 The block SHALL have port st_funct3, input, 3, store width: 000 SB, 001 SH, 010 SW.
REQ-006 The block SHALL have port st_addr, input, 32, byte address of the store.
REQ-007 The block SHALL have port st_data, input, 32, rs2 value, unaligned and LSB-justified.
REQ-008 The block SHALL have port st_stall, output, 1, high when the buffer is full; the pipeline holds the store.
REQ-009 The block SHALL have port st_fault, output, 1, registered one-cycle pulse for a misaligned or illegal store.
REQ-010 The block SHALL have port ld_addr, input, 32, address of a load in MEM this cycle.
REQ-011 The block SHALL have port ld_hazard, output, 1, high when any valid entry matches ld_addr[31:2].
REQ-012 The block SHALL have port mem_req, output, 1, write request to data memory.
REQ-013 The block SHALL have port mem_addr, output, 32, word address with bits [1:0] forced to 00.
REQ-014 The block SHALL have port mem_wdata, output, 32, lane-replicated write data.
REQ-015 The block SHALL have port mem_be, output, 4, byte enables; bit i enables byte i.
REQ-016 The block SHALL have port mem_ack, input, 1, memory accepted the current write.
REQ-017 The block SHALL have port sb_empty, output, 1, no pending entries.

Function
REQ-018 SB encoding SHALL be: be = 4'b0001 << st_addr[1:0]; wdata = {4{st_data[7:0]}}; never misaligned.
REQ-019 SH encoding SHALL be: st_addr[1]=0 gives be 0011, st_addr[1]=1 gives be 1100; wdata = {2{st_data[15:0]}}; st_addr[0]=1 is misaligned.
REQ-020 SW encoding SHALL be: be 1111; wdata = st_data; st_addr[1:0]!=00 is misaligned.
REQ-021 Any other st_funct3 value SHALL be illegal.
REQ-022 A store that is misaligned or illegal SHALL NOT be enqueued and SHALL cause st_fault=1 exactly in the next cycle.
REQ-023 st_valid=1 with st_stall=0 and a legal, aligned store SHALL write one entry {addr[31:2], wdata, be} at the tail.
REQ-024 st_valid=1 while st_stall=1 SHALL be ignored, with no enqueue and no fault.
REQ-025 st_stall SHALL equal full, combinationally from the entry count, independent of mem_ack in the same cycle.
REQ-026 mem_req SHALL equal !empty; mem_addr, mem_wdata and mem_be SHALL come from the head entry and stay stable while mem_req=1 and mem_ack=0.
REQ-027 mem_ack SHALL be sampled only when mem_req=1; a sampled ack pops the head at the clock edge.
REQ-028 An entry accepted at edge N into an empty buffer SHALL present mem_req=1 in cycle N+1; minimum occupancy is 1 cycle with ack held high.
REQ-029 Push and pop in the same cycle SHALL leave the count unchanged and preserve FIFO order.
REQ-030 Read and write pointers SHALL be log2(DEPTH) bits, wrapping modulo DEPTH; the count range SHALL be 0..DEPTH.
REQ-031 ld_hazard SHALL be combinational over all valid entries, including the head being acked this cycle, and SHALL exclude the store being enqueued this cycle.

Reset
REQ-032 While rst=1 at an edge, pointers and count SHALL clear to 0 and st_fault SHALL clear to 0; entry contents are don't-care.
REQ-033 After reset, outputs SHALL read mem_req=0, sb_empty=1, st_stall=0, ld_hazard=0.
REQ-034 Reset asserted mid-transaction SHALL discard all pending entries, including an unacked head; mem_req SHALL be 0 in the cycle after the reset edge.

Verification
REQ-035 Scenario: SB at addr 0x1003, data 0xAABBCCDD, ack held high -> next cycle mem_addr=0x1000, be=1000, wdata=0xDDDDDDDD, then sb_empty=1.
REQ-036 Scenario: SH at 0x2002, data 0x1234 -> be=1100, wdata=0x12341234; SH at 0x2001 -> st_fault pulse, no mem_req.
REQ-037 Scenario: 4 SWs with DEPTH=4, mem_ack=0 -> st_stall=1 after the 4th; a 5th store is ignored; ack for 4 cycles drains entries in order.
REQ-038 Scenario: full buffer, st_valid and mem_ack both high -> exactly one pop; the store is not taken; st_stall drops next cycle.
REQ-039 Scenario: pending SW at 0x3000, ld_addr=0x3002 -> ld_hazard=1; ld_addr=0x3004 -> ld_hazard=0.
REQ-040 Scenario: 2 entries pending with mem_req=1, rst pulse for one cycle -> mem_req=0, sb_empty=1; a later ack causes no pop.
